// File: rtl/ahb_dma_xfer_ctrl.sv
// ahb_dma_xfer_ctrl: single-channel DMA transfer sequencer.
// Runs a read-then-write ping-pong of single beats. One data word is buffered
// between the read and write phases. Source and destination addresses advance
// by the transfer size after each accepted beat.
// Optional feature macro: AHB_DMA_1K_BOUNDARY_EN enables the brk_1k output,
// which flags a 1 KB boundary crossing. Without it, brk_1k is tied low.
module ahb_dma_xfer_ctrl #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch_load,
  input  logic [31:0]      src_addr_in,
  input  logic [31:0]      dst_addr_in,
  input  logic [CNT_W-1:0] tot_sz,
  input  logic [2:0]       size,
  input  logic             src_inc,
  input  logic             dst_inc,
  input  logic             ch_abort,
  input  logic             beat_rd_done,
  input  logic [31:0]      rd_data,
  input  logic             beat_wr_done,
  output logic [31:0]      src_addr,
  output logic [31:0]      dst_addr,
  output logic [31:0]      wr_data,
  output logic [CNT_W-1:0] remaining,
  output logic             rd_req,
  output logic             wr_req,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             brk_1k
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_wdata;
  logic [CNT_W-1:0] r_rem;
  logic [1:0]       r_size;
  logic             r_src_inc;
  logic             r_dst_inc;
  logic             r_err;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [31:0]      w_src_nxt;
  logic [31:0]      w_dst_nxt;

  // The increment is split into two 16-bit halves with an explicit carry
  // between them. The result matches a plain 32-bit add modulo 2^32.
  function automatic logic [31:0] addr_inc(input logic [31:0] a, input logic [1:0] sz);
    logic [16:0] lo;
    logic [15:0] hi;
    lo = {1'b0, a[15:0]} + (17'd1 << sz);
    hi = a[31:16] + {15'd0, lo[16]};
    return {hi, lo[15:0]};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and beat-acceptance qualifiers; abort wins over strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load_ok   = 1'b0;
    w_load_bad  = 1'b0;
    w_rd_acc    = 1'b0;
    w_wr_acc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ch_load) begin
          if (size <= 3'd2) begin
            w_load_ok   = 1'b1;
            w_state_nxt = (tot_sz == '0) ? S_DONE : S_RD;
          end else begin
            w_load_bad  = 1'b1;
          end
        end
      end
      S_RD: begin
        if (ch_abort) begin
          w_state_nxt = S_IDLE;
        end else if (beat_rd_done) begin
          w_rd_acc    = 1'b1;
          w_state_nxt = S_WR;
        end
      end
      S_WR: begin
        if (ch_abort) begin
          w_state_nxt = S_IDLE;
        end else if (beat_wr_done) begin
          w_wr_acc    = 1'b1;
          w_state_nxt = (r_rem <= CNT_W'(1)) ? S_DONE : S_RD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Next address values, shared by the address registers and boundary detect.
  always_comb begin
    w_src_nxt = r_src;
    w_dst_nxt = r_dst;
    if (w_load_ok) begin
      w_src_nxt = src_addr_in;
      w_dst_nxt = dst_addr_in;
    end else begin
      if (w_rd_acc && r_src_inc) w_src_nxt = addr_inc(r_src, r_size);
      if (w_wr_acc && r_dst_inc) w_dst_nxt = addr_inc(r_dst, r_size);
    end
  end

  // Job registers: addresses, counter, buffered data and latched job settings.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_wdata   <= '0;
      r_rem     <= '0;
      r_size    <= '0;
      r_src_inc <= 1'b0;
      r_dst_inc <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_src <= w_src_nxt;
      r_dst <= w_dst_nxt;
      r_err <= w_load_bad;
      if (w_load_ok) begin
        r_rem     <= tot_sz;
        r_size    <= size[1:0];
        r_src_inc <= src_inc;
        r_dst_inc <= dst_inc;
      end else if (w_wr_acc) begin
        r_rem     <= r_rem - CNT_W'(1);
      end
      if (w_rd_acc) r_wdata <= rd_data;
    end
  end

`ifdef AHB_DMA_1K_BOUNDARY_EN
  logic r_rd_seen;
  logic r_wr_seen;
  logic r_brk;
  logic w_rd_seen_nxt;
  logic w_wr_seen_nxt;

  // A break applies only after the first beat of a phase, and only at a 1 KB boundary.
  always_comb begin
    w_rd_seen_nxt = w_load_ok ? 1'b0 : (r_rd_seen | w_rd_acc);
    w_wr_seen_nxt = w_load_ok ? 1'b0 : (r_wr_seen | w_wr_acc);
  end

  // Boundary flag, registered alongside the address it refers to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_seen <= 1'b0;
      r_wr_seen <= 1'b0;
      r_brk     <= 1'b0;
    end else begin
      r_rd_seen <= w_rd_seen_nxt;
      r_wr_seen <= w_wr_seen_nxt;
      r_brk     <= ((w_state_nxt == S_RD) && (w_src_nxt[9:0] == 10'd0) && w_rd_seen_nxt) ||
                   ((w_state_nxt == S_WR) && (w_dst_nxt[9:0] == 10'd0) && w_wr_seen_nxt);
    end
  end

  assign brk_1k = r_brk;
`else
  assign brk_1k = 1'b0;
`endif

  assign src_addr  = r_src;
  assign dst_addr  = r_dst;
  assign wr_data   = r_wdata;
  assign remaining = r_rem;
  assign rd_req    = (r_state == S_RD);
  assign wr_req    = (r_state == S_WR);
  assign busy      = (r_state == S_RD) || (r_state == S_WR);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;

endmodule

// File: tb/tb_ahb_dma_xfer_ctrl.sv
// Bench for ahb_dma_xfer_ctrl: directed and random jobs with random wait states.
// Expected addresses are computed from each job's start address plus
// the beat count times the step size.
module tb_ahb_dma_xfer_ctrl;

  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             ch_load;
  logic [31:0]      src_addr_in;
  logic [31:0]      dst_addr_in;
  logic [CNT_W-1:0] tot_sz;
  logic [2:0]       size;
  logic             src_inc;
  logic             dst_inc;
  logic             ch_abort;
  logic             beat_rd_done;
  logic [31:0]      rd_data;
  logic             beat_wr_done;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [31:0]      wr_data;
  logic [CNT_W-1:0] remaining;
  logic             rd_req;
  logic             wr_req;
  logic             busy;
  logic             done;
  logic             err;
  logic             brk_1k;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] m_src = '0;
  logic [31:0] m_dst = '0;

  ahb_dma_xfer_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ch_load(ch_load), .src_addr_in(src_addr_in),
    .dst_addr_in(dst_addr_in), .tot_sz(tot_sz), .size(size), .src_inc(src_inc),
    .dst_inc(dst_inc), .ch_abort(ch_abort), .beat_rd_done(beat_rd_done),
    .rd_data(rd_data), .beat_wr_done(beat_wr_done), .src_addr(src_addr),
    .dst_addr(dst_addr), .wr_data(wr_data), .remaining(remaining),
    .rd_req(rd_req), .wr_req(wr_req), .busy(busy), .done(done), .err(err),
    .brk_1k(brk_1k)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic brk_exp(input logic [31:0] a, input int beats_done);
`ifdef AHB_DMA_1K_BOUNDARY_EN
    return (beats_done > 0) && (a[9:0] == 10'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Runs one job. abort_at >= 0 aborts during the write phase of that transfer index.
  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int tot,
                         input logic [2:0] sz, input logic si, input logic di,
                         input int abort_at, input bit nowait);
    logic [31:0] ss, sd, data, ea;
    int cyc, w;
    ss = si ? (32'd1 << sz) : 32'd0;
    sd = di ? (32'd1 << sz) : 32'd0;
    src_addr_in = s; dst_addr_in = d; tot_sz = CNT_W'(tot); size = sz;
    src_inc = si; dst_inc = di; ch_load = 1'b1;
    step();
    ch_load = 1'b0;
    cyc = 1;
    m_src = s; m_dst = d;
    if (tot == 0) begin
      chk("zero_done", done, 1);
      chk("zero_rdreq", rd_req, 0);
      chk("zero_busy", busy, 0);
      chk("zero_rem", remaining, 0);
      step();
      chk("zero_done_clr", done, 0);
      return;
    end
    for (int k = 0; k < tot; k++) begin
      ea = s + ss * 32'(k);
      chk("rd_req", rd_req, 1);
      chk("rd_wrreq", wr_req, 0);
      chk("rd_busy", busy, 1);
      chk("rd_src", src_addr, ea);
      chk("rd_rem", remaining, 32'(tot - k));
      chk("rd_brk", brk_1k, brk_exp(ea, k));
      w = nowait ? 0 : int'($urandom_range(0, 2));
      repeat (w) begin
        beat_wr_done = 1'b1; ch_load = 1'b1; src_addr_in = $urandom; size = 3'd5;
        step(); cyc++;
        beat_wr_done = 1'b0; ch_load = 1'b0;
        chk("rdw_src", src_addr, ea);
        chk("rdw_dst", dst_addr, d + sd * 32'(k));
        chk("rdw_rdreq", rd_req, 1);
        chk("rdw_err", err, 0);
      end
      data = $urandom;
      rd_data = data; beat_rd_done = 1'b1;
      step(); cyc++;
      beat_rd_done = 1'b0;
      m_src = s + ss * 32'(k + 1);
      chk("wr_req", wr_req, 1);
      chk("wr_rdreq", rd_req, 0);
      chk("wr_data", wr_data, data);
      chk("wr_src", src_addr, m_src);
      chk("wr_dst", dst_addr, d + sd * 32'(k));
      chk("wr_brk", brk_1k, brk_exp(d + sd * 32'(k), k));
      if (abort_at == k) begin
        ch_abort = 1'b1; beat_wr_done = 1'b1;
        step();
        ch_abort = 1'b0; beat_wr_done = 1'b0;
        m_dst = d + sd * 32'(k);
        chk("ab_busy", busy, 0);
        chk("ab_wrreq", wr_req, 0);
        chk("ab_rdreq", rd_req, 0);
        chk("ab_done", done, 0);
        chk("ab_rem", remaining, 32'(tot - k));
        chk("ab_dst", dst_addr, m_dst);
        step();
        chk("ab_done2", done, 0);
        return;
      end
      repeat (w) begin
        beat_rd_done = 1'b1; rd_data = ~data;
        step(); cyc++;
        beat_rd_done = 1'b0;
        chk("wrw_data", wr_data, data);
        chk("wrw_wrreq", wr_req, 1);
      end
      beat_wr_done = 1'b1;
      step(); cyc++;
      beat_wr_done = 1'b0;
      m_dst = d + sd * 32'(k + 1);
      chk("post_dst", dst_addr, m_dst);
      chk("post_rem", remaining, 32'(tot - k - 1));
    end
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_rdreq", rd_req, 0);
    if (nowait) chk("latency", 32'(cyc), 32'(2 * tot + 1));
    step();
    chk("done_clr", done, 0);
    chk("final_rem", remaining, 0);
    chk("final_src", src_addr, m_src);
    chk("final_dst", dst_addr, m_dst);
  endtask

  initial begin
    rst = 1'b1; ch_load = 1'b0; src_addr_in = '0; dst_addr_in = '0; tot_sz = '0;
    size = '0; src_inc = 1'b0; dst_inc = 1'b0; ch_abort = 1'b0;
    beat_rd_done = 1'b0; rd_data = '0; beat_wr_done = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_src", src_addr, 0);
    chk("rst_dst", dst_addr, 0);
    chk("rst_wdata", wr_data, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_ctrl", {26'd0, rd_req, wr_req, busy, done, err, brk_1k}, 0);

    // Word copy with zero-wait strobes
    run_job(32'h1000, 32'h2000, 3, 3'd2, 1'b1, 1'b1, -1, 1'b1);
    // Fixed destination, byte size
    run_job(32'h10, 32'h40, 4, 3'd0, 1'b1, 1'b0, -1, 1'b0);
    // Address wrap and 16-bit carry
    run_job(32'hFFFF_FFFC, 32'h80, 2, 3'd2, 1'b1, 1'b1, -1, 1'b0);
    run_job(32'h0000_FFFE, 32'h0001_FFFE, 2, 3'd1, 1'b1, 1'b1, -1, 1'b1);
    // Abort in WR after one completed transfer; next load accepted
    run_job(32'h3000, 32'h4000, 5, 3'd2, 1'b1, 1'b1, 1, 1'b0);
    run_job(32'h5000, 32'h6000, 2, 3'd1, 1'b1, 1'b1, -1, 1'b1);

    // Illegal size: err pulse, no register change
    src_addr_in = 32'hDEAD_BEEF; dst_addr_in = 32'hCAFE_0000; tot_sz = 12'd7;
    size = 3'd3; ch_load = 1'b1;
    step();
    ch_load = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    chk("ill_rdreq", rd_req, 0);
    chk("ill_src", src_addr, m_src);
    chk("ill_dst", dst_addr, m_dst);
    chk("ill_rem", remaining, 0);
    step();
    chk("ill_err_clr", err, 0);

    // Zero-length job
    run_job(32'h7000, 32'h8000, 0, 3'd2, 1'b1, 1'b1, -1, 1'b0);
    // 1 KB boundary crossing on reads
    run_job(32'h3F8, 32'h1000, 4, 3'd2, 1'b1, 1'b1, -1, 1'b0);

    // Random jobs
    for (int j = 0; j < 10; j++) begin
      run_job($urandom, $urandom, int'($urandom_range(1, 6)), 3'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              (j % 4 == 3) ? int'($urandom_range(0, 0)) : -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
